// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion.
// One 32-bit schedule word is produced per unstalled cycle from a sliding
// window of the last NK words; every fourth word completes a 128-bit round
// key which is offered on a valid/ready handshake.
// Optional feature macro: AES_KEYSCHED_REVERSE_EN -- buffers the whole
// schedule and emits round keys last-to-first for the decryption datapath.
// Without the macro, rev is ignored and keys are emitted in forward order.

// Combinational AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] w_pow;
  logic [7:0] w_inv;

  // Multiplicative inverse by square-and-multiply: x^2 * x^4 * ... * x^128 = x^254 (0 maps to 0).
  always_comb begin
    w_pow = i_byte;
    w_inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      w_pow = gf_mul(w_pow, w_pow);
      w_inv = gf_mul(w_inv, w_pow);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

module aes_key_schedule #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic         rev,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_I = 6'(NW - 1);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_RLOAD,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Expansion state
  logic [31:0]  r_key_w [8];
  logic [31:0]  r_win [NK];   // r_win[NK-1] = w[i-1], r_win[0] = w[i-NK]
  logic [5:0]   r_i;
  logic [2:0]   r_mod;        // i % NK, tracked incrementally since NK=6 is not a power of two
  logic [7:0]   r_rcon;

  // Output registers
  logic         r_rk_valid;
  logic [127:0] r_rk;
  logic [3:0]   r_rk_round;
  logic         r_done;

  // Datapath wires
  logic         w_stall;
  logic         w_xfer;
  logic         w_gen;
  logic         w_from_key;
  logic         w_rot_word;
  logic         w_sub_only;
  logic [31:0]  w_prev;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_temp;
  logic [31:0]  w_word;
  logic [127:0] w_rk_word;
  logic         w_rk_load;
  logic         w_last_word;
  logic         w_rev_mode;
  logic         w_more_rev;
  logic         w_finish;

`ifdef AES_KEYSCHED_REVERSE_EN
  logic         r_rev;
  logic [3:0]   r_rd_round;
  logic [127:0] r_buf [NR+1];

  assign w_rev_mode = r_rev;
  assign w_more_rev = r_rev && (r_rd_round != 4'd0);
`else
  logic         w_unused_rev;

  assign w_rev_mode   = 1'b0;
  assign w_more_rev   = 1'b0;
  assign w_unused_rev = rev;
`endif

  // Handshake / stall qualification
  assign w_stall     = r_rk_valid && !rk_ready;
  assign w_xfer      = r_rk_valid && rk_ready;
  assign w_gen       = (r_state == S_EXPAND) && !w_stall;
  assign w_last_word = (r_i == LAST_I);

  // Word-rule selection
  assign w_from_key = (r_i < NK_W);
  assign w_rot_word = !w_from_key && (r_mod == 3'd0);
  assign w_sub_only = (NK == 8) && !w_from_key && (r_mod == 3'd4);

  assign w_prev   = r_win[NK-1];
  assign w_sub_in = w_rot_word ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  // SubWord: one S-box per byte lane
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .i_byte (w_sub_in[8*gi +: 8]),
        .o_byte (w_sub_out[8*gi +: 8])
      );
    end
  endgenerate

  // Core recurrence: transform temp according to the word position, fold into w[i-NK].
  always_comb begin
    w_temp = w_prev;
    if (w_rot_word) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h000000};
    end else if (w_sub_only) begin
      w_temp = w_sub_out;
    end
    w_word = w_from_key ? r_key_w[r_mod] : (r_win[0] ^ w_temp);
  end

  // The three previous words plus the new one form the round key when i%4==3.
  assign w_rk_word = {r_win[NK-3], r_win[NK-2], r_win[NK-1], w_word};
  assign w_rk_load = w_gen && (r_i[1:0] == 2'b11);
  assign w_finish  = (r_state == S_DRAIN) && w_xfer && !w_more_rev;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_EXPAND;
      end
      S_EXPAND: begin
        if (w_gen && w_last_word) w_state_next = w_rev_mode ? S_RLOAD : S_DRAIN;
      end
      S_RLOAD: begin
        w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_xfer) w_state_next = w_more_rev ? S_RLOAD : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Key latch, word counter, rcon and sliding window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= 8'h00;
      for (int j = 0; j < 8; j++) r_key_w[j] <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      for (int j = 0; j < 8; j++) r_key_w[j] <= key[255 - 32*j -: 32];
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= 8'h01;
    end else if (w_gen) begin
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_word;
      r_i         <= r_i + 6'd1;
      r_mod       <= (r_mod == NK_M1) ? 3'd0 : r_mod + 3'd1;
      if (w_rot_word) begin
        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // Round-key output register and handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rk_valid <= 1'b0;
      r_rk       <= '0;
      r_rk_round <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_rk_load && !w_rev_mode) begin
        r_rk       <= w_rk_word;
        r_rk_round <= r_i[5:2];
        r_rk_valid <= 1'b1;
`ifdef AES_KEYSCHED_REVERSE_EN
      end else if (r_state == S_RLOAD) begin
        r_rk       <= r_buf[r_rd_round];
        r_rk_round <= r_rd_round;
        r_rk_valid <= 1'b1;
`endif
      end else if (w_xfer) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

`ifdef AES_KEYSCHED_REVERSE_EN
  // Reverse-mode control: latch rev with start, walk the read index from NR down to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rev      <= 1'b0;
      r_rd_round <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_rev <= rev;
      end
      if ((r_state == S_EXPAND) && w_gen && w_last_word) begin
        r_rd_round <= 4'(NR);
      end else if ((r_state == S_DRAIN) && w_xfer && w_more_rev) begin
        r_rd_round <= r_rd_round - 4'd1;
      end
    end
  end

  // Round-key buffer: written during expansion, read when the next key is loaded.
  always_ff @(posedge clk) begin
    if (w_rk_load && r_rev) begin
      r_buf[r_i[5:2]] <= w_rk_word;
    end
  end
`endif

  assign busy     = (r_state != S_IDLE);
  assign rk_valid = r_rk_valid;
  assign rk       = r_rk;
  assign rk_round = r_rk_round;
  assign done     = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: checks NK=4/6/8 instances against a table-based
// reference expansion, known-answer vectors, backpressure, reset abort,
// back-to-back starts and (when compiled with the feature) reverse order.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] key;
  logic         rev;
  logic         st  [3];
  logic         rdy [3];
  logic         bsy [3];
  logic         vld [3];
  logic         dn  [3];
  logic [127:0] rko [3];
  logic [3:0]   rno [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t   [256];
  logic [7:0]   rcon_tab [10];
  logic [127:0] cap  [3][15];
  logic [127:0] gold [11];

`ifdef AES_KEYSCHED_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  typedef struct {
    int           d;
    logic [255:0] k;
    int           r;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  aes_key_schedule #(.NK(4)) u_nk4 (
    .clk(clk), .reset_n(reset_n), .start(st[0]), .key(key), .rev(rev),
    .busy(bsy[0]), .rk_valid(vld[0]), .rk_ready(rdy[0]), .rk(rko[0]),
    .rk_round(rno[0]), .done(dn[0]));

  aes_key_schedule #(.NK(6)) u_nk6 (
    .clk(clk), .reset_n(reset_n), .start(st[1]), .key(key), .rev(rev),
    .busy(bsy[1]), .rk_valid(vld[1]), .rk_ready(rdy[1]), .rk(rko[1]),
    .rk_round(rno[1]), .done(dn[1]));

  aes_key_schedule #(.NK(8)) u_nk8 (
    .clk(clk), .reset_n(reset_n), .start(st[2]), .key(key), .rev(rev),
    .busy(bsy[2]), .rk_valid(vld[2]), .rk_ready(rdy[2]), .rk(rko[2]),
    .rk_round(rno[2]), .done(dn[2]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box table from the generator-3 log walk (p runs over powers of 3, q over its inverses).
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Full schedule expansion straight from the word rules; returns round key r.
  function automatic logic [127:0] ref_rk(input logic [255:0] k, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // One expansion on DUT d. Entered and left at a negedge; start is sampled at the next posedge (edge 0).
  task automatic do_run(input int d, input logic [255:0] k, input logic rv, input int rmode,
                        input int stall_rnd, input int stall_len, input int poke_edge,
                        input int abort_rnd, output int done_e);
    int nr, nw, seen, shown, stalls, held, edge_k, last_hs, exp_r, exp_edge;
    bit rev_act, fin, aborted;
    logic v;
    logic [127:0] rk_s;
    logic [3:0]   rn_s;
    nr = 4 + 2*d + 6;
    nw = 4 * (nr + 1);
    rev_act = rv && REV_EN;
    seen = 0; shown = -1; stalls = 0; held = 0; edge_k = 0; last_hs = -1;
    fin = 1'b0; aborted = 1'b0; done_e = -1;
    key = k; rev = rv; st[d] = 1'b1; rdy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[d] = 1'b0;
    chk("busy_after_start", bsy[d], 1'b1);
    chk("done_low_after_start", dn[d], 1'b0);
    while (!fin) begin
      if (dn[d]) begin
        chk("done_edge", edge_k, last_hs);
        chk("key_count", seen, nr + 1);
        chk("busy_low_at_done", bsy[d], 1'b0);
        done_e = edge_k;
        fin = 1'b1;
      end else if (edge_k > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: got no done after %0d edges, required done", edge_k);
        fin = 1'b1;
      end else begin
        v = vld[d]; rk_s = rko[d]; rn_s = rno[d];
        if (v) begin
          exp_r = rev_act ? nr - seen : seen;
          chk("rk_round", rn_s, exp_r);
          chk("rk_value", rk_s, ref_rk(k, 4 + 2*d, exp_r));
          if (shown != seen) begin
            exp_edge = rev_act ? ((seen == 0) ? nw + 1 : last_hs + 1) : 4*seen + 4 + stalls;
            chk("rk_valid_edge", edge_k, exp_edge);
            shown = seen;
          end
        end
        rdy[d] = 1'b1;
        if (rmode == 1) rdy[d] = ($urandom_range(0, 3) != 0);
        if (v && seen == stall_rnd && held < stall_len) begin
          rdy[d] = 1'b0;
          held++;
        end
        if (edge_k == poke_edge) begin
          st[d] = 1'b1; key = ~k;
        end else begin
          st[d] = 1'b0; key = k;
        end
        @(posedge clk);
        edge_k++;
        if (v && !rdy[d]) stalls++;
        if (v && rdy[d]) begin
          cap[d][rn_s] = rk_s;
          seen++;
          last_hs = edge_k;
        end
        if (abort_rnd >= 0 && seen == abort_rnd + 1) begin
          #2 reset_n = 1'b0;
          #1;
          chk("reset_clears_outputs", {bsy[d], vld[d], dn[d], rno[d], rko[d]}, '0);
          @(negedge clk);
          reset_n = 1'b1;
          st[d] = 1'b0; key = k;
          aborted = 1'b1;
          fin = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    st[d] = 1'b0;
    $display("run nk=%0d rev=%0d key=%h keys=%0d stalls=%0d done_edge=%0d aborted=%0d",
             4 + 2*d, rv, k[255 -: 64], seen, stalls, done_e, aborted);
  endtask

  initial begin
    logic [255:0] k4, k6, k8, kr;
    int de;
    build_tables();
    k4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    vecs[0] = '{0, k4, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{0, k4, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{0, k4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{1, k6, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[4] = '{1, k6, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    vecs[5] = '{2, k8, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};

    reset_n = 1'b0; key = '0; rev = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; rdy[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 3; d++) chk("reset_state", {bsy[d], vld[d], dn[d], rno[d], rko[d]}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Forward runs with rk_ready high
    do_run(0, k4, 1'b0, 0, -1, 0, -1, -1, de);
    chk("nk4_done_edge", de, 45);
    for (int r = 0; r < 11; r++) gold[r] = cap[0][r];
    do_run(1, k6, 1'b0, 0, -1, 0, -1, -1, de);
    chk("nk6_done_edge", de, 53);
    do_run(2, k8, 1'b0, 0, -1, 0, -1, -1, de);
    chk("nk8_done_edge", de, 61);

    // Known-answer table against both the model and the captured DUT keys
    for (int v = 0; v < 6; v++) begin
      chk("model_vs_table", ref_rk(vecs[v].k, 4 + 2*vecs[v].d, vecs[v].r), vecs[v].exp);
      chk("dut_vs_table", cap[vecs[v].d][vecs[v].r], vecs[v].exp);
    end

    // 5-cycle backpressure on r1, plus a start pulse while busy
    do_run(0, k4, 1'b0, 0, 1, 5, 12, -1, de);
    chk("stall_done_edge", de, 50);

    // Abort after r3 handshake, then restart with the same key
    do_run(0, k4, 1'b0, 0, -1, 0, -1, 3, de);
    for (int r = 0; r < 11; r++) cap[0][r] = '0;
    do_run(0, k4, 1'b0, 0, -1, 0, -1, -1, de);
    for (int r = 0; r < 11; r++) chk("restart_reproduces", cap[0][r], gold[r]);

`ifdef AES_KEYSCHED_REVERSE_EN
    do_run(0, k4, 1'b1, 0, -1, 0, -1, -1, de);
    chk("rev_first_key", cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("rev_last_key", cap[0][0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif

    // Randomized keys, rev and ready, run back-to-back
    for (int n = 0; n < 12; n++) begin
      for (int w = 0; w < 8; w++) kr[32*w +: 32] = $urandom;
      do_run($urandom_range(0, 2), kr, 1'($urandom_range(0, 1)), 1, -1, 0, -1, -1, de);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
